// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer/decoder: fetch, decode and execute control for the slc3 datapath.
// Optional PAUSE_EN macro enables the 1101 pause states (LD_LED, Continue handshake).
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Instr_Done
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    HALTED, S18, RD, WR, S35, S32,
    S01, S05, S09, S00, S22, S12, S04, S21, S20, S14,
    S02, S06, S27, S10, S26, S03, S07, S23, S11, S29
`ifdef PAUSE_EN
    , PAUSE_IR1, PAUSE_IR2
`endif
  } state_t;

  state_t        state_q, state_d;
  state_t        ret_q, ret_d;   // where RD hands control back after the access
  logic [CW-1:0] cnt_q, cnt_d;

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

`ifndef PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= HALTED;
      ret_q   <= S35;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = '0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Instr_Done = 1'b0;

    case (state_q)
      HALTED: if (Run) state_d = S18;
      S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
        state_d = RD; ret_d = S35;
      end
      RD: begin
        Mem_OE = 1'b0;
        if (cnt_q == LAST) begin
          LD_MDR  = 1'b1;
          state_d = ret_q;
        end else cnt_d = cnt_q + CW'(1);
      end
      WR: begin
        Mem_WE = 1'b0;
        if (cnt_q == LAST) begin
          Instr_Done = 1'b1;
          state_d    = S18;
        end else cnt_d = cnt_q + CW'(1);
      end
      S35: begin GateMDR = 1'b1; LD_IR = 1'b1; state_d = S32; end
      S32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: state_d = S01;
          4'b0101: state_d = S05;
          4'b1001: state_d = S09;
          4'b0000: state_d = S00;
          4'b1100: state_d = S12;
          4'b0100: state_d = S04;
          4'b1110: state_d = S14;
          4'b0010: state_d = S02;
          4'b0110: state_d = S06;
          4'b1010: state_d = S10;
          4'b0011: state_d = S03;
          4'b0111: state_d = S07;
          4'b1011: state_d = S11;
`ifdef PAUSE_EN
          4'b1101: state_d = PAUSE_IR1;
`endif
          default: begin Instr_Done = 1'b1; state_d = S18; end
        endcase
      end
      S01, S05, S09: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; Instr_Done = 1'b1;
        ALUK    = (state_q == S01) ? 2'b00 : (state_q == S05) ? 2'b01 : 2'b10;
        SR2MUX  = (state_q != S09) & IR_5;
        state_d = S18;
      end
      S00: begin
        if (BEN) state_d = S22;
        else begin Instr_Done = 1'b1; state_d = S18; end
      end
      S22: begin
        ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; Instr_Done = 1'b1;
        state_d = S18;
      end
      S12, S20: begin
        ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; Instr_Done = 1'b1;
        state_d = S18;
      end
      S04: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
        state_d = IR_11 ? S21 : S20;
      end
      S21: begin
        ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1; Instr_Done = 1'b1;
        state_d = S18;
      end
      S14: begin
        ADDR2MUX = 2'b10; GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        Instr_Done = 1'b1; state_d = S18;
      end
      // PC-relative address into MAR, then branch on which memory op follows
      S02, S10, S03, S11: begin
        ADDR2MUX = 2'b10; GateMARMUX = 1'b1; LD_MAR = 1'b1;
        case (state_q)
          S02:     begin state_d = RD; ret_d = S27; end
          S10:     begin state_d = RD; ret_d = S26; end
          S11:     begin state_d = RD; ret_d = S29; end
          default: state_d = S23;
        endcase
      end
      S06, S07: begin
        ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
        if (state_q == S06) begin state_d = RD; ret_d = S27; end
        else state_d = S23;
      end
      S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; Instr_Done = 1'b1;
        state_d = S18;
      end
      S26: begin GateMDR = 1'b1; LD_MAR = 1'b1; state_d = RD; ret_d = S27; end
      S29: begin GateMDR = 1'b1; LD_MAR = 1'b1; state_d = S23; end
      S23: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
        state_d = WR;
      end
`ifdef PAUSE_EN
      PAUSE_IR1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = PAUSE_IR2;
      end
      PAUSE_IR2: begin
        if (!Continue) begin Instr_Done = 1'b1; state_d = S18; end
      end
`endif
      default: state_d = HALTED;
    endcase
  end

endmodule
